// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared state encoding and active-low grant levels for the bus tenure arbiter
package bus_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT,
        ARB_TURN
    } bus_arb_state_e;

    // Grant and request lines are active-low.
    localparam logic ENABLE  = 1'b0;
    localparam logic DISABLE = 1'b1;

endpackage

// File: rtl/bus_tenure_arbiter_if.sv
// rtl/bus_tenure_arbiter_if.sv - request/grant bundle between bus masters and the tenure arbiter
interface bus_tenure_arbiter_if #(
    parameter int N_MST = 4
);
    localparam int OW = $clog2(N_MST);

    logic [N_MST-1:0] m_reqn;
    logic [N_MST-1:0] m_lockn;
    logic [N_MST-1:0] m_grntn;
    logic [OW-1:0]    bus_owner;
    logic             bus_owner_vld;
    logic             preempt_pulse;

    modport master (
        output m_reqn,
        output m_lockn,
        input  m_grntn,
        input  bus_owner,
        input  bus_owner_vld,
        input  preempt_pulse
    );

    modport slave (
        input  m_reqn,
        input  m_lockn,
        output m_grntn,
        output bus_owner,
        output bus_owner_vld,
        output preempt_pulse
    );

endinterface

// File: rtl/bus_rr_picker.sv
// rtl/bus_rr_picker.sv - combinational round-robin picker, priority wraps upward from start_i
module bus_rr_picker #(
    parameter int N_MST = 4
) (
    input  logic [N_MST-1:0]         req_i,
    input  logic [$clog2(N_MST)-1:0] start_i,
    output logic [$clog2(N_MST)-1:0] win_o,
    output logic                     any_o
);
    localparam int OW = $clog2(N_MST);

    int idx;

    // Walk from the lowest priority back to start_i so the last hit is the winner.
    always_comb begin
        win_o = '0;
        any_o = 1'b0;
        idx   = 0;
        for (int i = N_MST - 1; i >= 0; i--) begin
            idx = (int'(start_i) + i) % N_MST;
            if (req_i[idx]) begin
                win_o = OW'(idx);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_tenure_arbiter.sv
// rtl/bus_tenure_arbiter.sv - round-robin bus owner arbiter with bounded tenure and turnaround gap
// Optional BUS_ARB_LOCK_EN: an owner holding m_lockn low cannot be preempted.
module bus_tenure_arbiter
    import bus_arb_pkg::*;
#(
    parameter int N_MST      = 4,
    parameter int MAX_TENURE = 16,
    parameter int TURN_CYC   = 1
) (
    input logic                 bus_clk,
    input logic                 bus_rst,
    bus_tenure_arbiter_if.slave bus
);
    localparam int OW = $clog2(N_MST);

    bus_arb_state_e   state_q, state_d;
    logic [7:0]       tenure_q, tenure_d;
    logic [3:0]       turn_cnt_q, turn_cnt_d;
    logic [OW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [N_MST-1:0] grntn_q, grntn_d;
    logic [OW-1:0]    owner_q, owner_d;
    logic             vld_q, vld_d;
    logic             pulse_q, pulse_d;

    logic [N_MST-1:0] req;
    logic [N_MST-1:0] own_mask;
    logic             owner_req;
    logic             others_req;
    logic             lock_hold;
    logic [OW-1:0]    pick_win;
    logic             pick_any;
    logic [OW-1:0]    next_ptr;

    assign req        = ~bus.m_reqn;
    assign own_mask   = N_MST'(1) << owner_q;
    assign owner_req  = |(req & own_mask);
    assign others_req = |(req & ~own_mask);
    assign next_ptr   = (owner_q == OW'(N_MST - 1)) ? '0 : owner_q + 1'b1;

`ifdef BUS_ARB_LOCK_EN
    assign lock_hold = ~|(bus.m_lockn & own_mask);
`else
    logic unused_lockn;
    assign unused_lockn = &bus.m_lockn;
    assign lock_hold    = 1'b0;
`endif

    bus_rr_picker #(
        .N_MST (N_MST)
    ) u_picker (
        .req_i   (req),
        .start_i (rr_ptr_q),
        .win_o   (pick_win),
        .any_o   (pick_any)
    );

    always_comb begin
        state_d    = state_q;
        tenure_d   = tenure_q;
        turn_cnt_d = turn_cnt_q;
        rr_ptr_d   = rr_ptr_q;
        grntn_d    = grntn_q;
        owner_d    = owner_q;
        vld_d      = vld_q;
        pulse_d    = 1'b0;

        unique case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    grntn_d           = {N_MST{DISABLE}};
                    grntn_d[pick_win] = ENABLE;
                    owner_d           = pick_win;
                    vld_d             = 1'b1;
                    tenure_d          = 8'd1;
                    state_d           = ARB_GRANT;
                end
            end

            ARB_GRANT: begin
                // Release is checked first so a voluntary handover never reports a preempt.
                if (!owner_req) begin
                    grntn_d    = {N_MST{DISABLE}};
                    vld_d      = 1'b0;
                    rr_ptr_d   = next_ptr;
                    turn_cnt_d = 4'd1;
                    tenure_d   = 8'd0;
                    state_d    = ARB_TURN;
                end else if (tenure_q == 8'(MAX_TENURE) && others_req && !lock_hold) begin
                    grntn_d    = {N_MST{DISABLE}};
                    vld_d      = 1'b0;
                    pulse_d    = 1'b1;
                    rr_ptr_d   = next_ptr;
                    turn_cnt_d = 4'd1;
                    tenure_d   = 8'd0;
                    state_d    = ARB_TURN;
                end else if (tenure_q < 8'(MAX_TENURE)) begin
                    tenure_d = tenure_q + 8'd1;
                end
            end

            ARB_TURN: begin
                if (turn_cnt_q >= 4'(TURN_CYC)) begin
                    turn_cnt_d = 4'd0;
                    if (pick_any) begin
                        grntn_d           = {N_MST{DISABLE}};
                        grntn_d[pick_win] = ENABLE;
                        owner_d           = pick_win;
                        vld_d             = 1'b1;
                        tenure_d          = 8'd1;
                        state_d           = ARB_GRANT;
                    end else begin
                        state_d = ARB_IDLE;
                    end
                end else begin
                    turn_cnt_d = turn_cnt_q + 4'd1;
                end
            end

            default: begin
                grntn_d = {N_MST{DISABLE}};
                vld_d   = 1'b0;
                state_d = ARB_IDLE;
            end
        endcase
    end

    always_ff @(posedge bus_clk) begin
        if (bus_rst) begin
            state_q    <= ARB_IDLE;
            tenure_q   <= 8'd0;
            turn_cnt_q <= 4'd0;
            rr_ptr_q   <= '0;
            grntn_q    <= {N_MST{DISABLE}};
            owner_q    <= '0;
            vld_q      <= 1'b0;
            pulse_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            tenure_q   <= tenure_d;
            turn_cnt_q <= turn_cnt_d;
            rr_ptr_q   <= rr_ptr_d;
            grntn_q    <= grntn_d;
            owner_q    <= owner_d;
            vld_q      <= vld_d;
            pulse_q    <= pulse_d;
        end
    end

    assign bus.m_grntn       = grntn_q;
    assign bus.bus_owner     = owner_q;
    assign bus.bus_owner_vld = vld_q;
    assign bus.preempt_pulse = pulse_q;

endmodule

// File: tb/tb_bus_tenure_arbiter.sv
// tb/tb_bus_tenure_arbiter.sv - vector-table bench with scoreboard queue for bus_tenure_arbiter
module tb_bus_tenure_arbiter;

    typedef struct {
        logic       rst;
        logic [3:0] reqn;
        logic [3:0] lockn;
        logic [3:0] grntn;
        logic       vld;
        logic [1:0] owner;
        logic       chk_owner;
        logic       pulse;
    } vec_t;

    localparam logic [3:0] NONE = 4'hF;

    logic bus_clk = 1'b0;
    logic bus_rst = 1'b1;

    bus_tenure_arbiter_if #(.N_MST(4)) bus_if ();

    bus_tenure_arbiter #(
        .N_MST      (4),
        .MAX_TENURE (16),
        .TURN_CYC   (1)
    ) dut (
        .bus_clk (bus_clk),
        .bus_rst (bus_rst),
        .bus     (bus_if.slave)
    );

    always #5 bus_clk = ~bus_clk;

    vec_t vecs[$];
    vec_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   vi     = 0;

    function automatic logic [3:0] g(input int w);
        logic [3:0] v;
        v    = NONE;
        v[w] = 1'b0;
        return v;
    endfunction

    task automatic add(input logic rst, input logic [3:0] reqn, input logic [3:0] lockn,
                       input logic [3:0] exp_g, input logic pulse);
        vec_t v;
        v.rst   = rst;
        v.reqn  = reqn;
        v.lockn = lockn;
        v.grntn = exp_g;
        v.vld   = (exp_g != NONE);
        v.pulse = pulse;
        v.owner = 2'd0;
        for (int i = 0; i < 4; i++)
            if (!exp_g[i]) v.owner = 2'(i);
        v.chk_owner = v.vld | rst;
        vecs.push_back(v);
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h want %0h", nm, vi, act, exp);
        end
    endtask

    // M0 holds, M2 joins at the third granted cycle; locked selects the no-preempt response.
    task automatic scen_preempt(input logic [3:0] lk, input bit locked);
        add(1'b1, 4'b0000, lk, NONE, 1'b0);
        add(1'b0, 4'b1110, lk, g(0), 1'b0);
        for (int j = 1; j <= 15; j++)
            add(1'b0, (j >= 3) ? 4'b1010 : 4'b1110, lk, g(0), 1'b0);
        if (!locked) begin
            add(1'b0, 4'b1010, lk, NONE, 1'b1);
            add(1'b0, 4'b1010, lk, g(2), 1'b0);
            add(1'b0, 4'b1110, lk, NONE, 1'b0);
            add(1'b0, 4'b1110, lk, g(0), 1'b0);
        end else begin
            for (int j = 0; j < 5; j++)
                add(1'b0, 4'b1010, lk, g(0), 1'b0);
            add(1'b0, 4'b1011, lk, NONE, 1'b0);
            add(1'b0, 4'b1011, lk, g(2), 1'b0);
        end
    endtask

    initial begin
        int w;
        bus_if.m_reqn  = 4'hF;
        bus_if.m_lockn = 4'hF;

        // Reset held two cycles with everyone requesting.
        add(1'b1, 4'b0000, NONE, NONE, 1'b0);
        add(1'b1, 4'b0000, NONE, NONE, 1'b0);

        // Single master: grant, hold, release, turn, idle.
        for (int j = 0; j < 6; j++)
            add(1'b0, 4'b1110, NONE, g(0), 1'b0);
        add(1'b0, 4'b1111, NONE, NONE, 1'b0);
        add(1'b0, 4'b1111, NONE, NONE, 1'b0);
        add(1'b0, 4'b1111, NONE, NONE, 1'b0);
        // From idle with rr_ptr at 1, M0 and M1 request: M1 wins.
        add(1'b0, 4'b1100, NONE, g(1), 1'b0);

        // Round-robin with all requesting, 3 granted cycles each.
        add(1'b1, 4'b0000, NONE, NONE, 1'b0);
        add(1'b0, 4'b0000, NONE, g(0), 1'b0);
        for (int i = 0; i < 4; i++) begin
            w = i % 4;
            add(1'b0, 4'b0000, NONE, g(w), 1'b0);
            add(1'b0, 4'b0000, NONE, g(w), 1'b0);
            add(1'b0, 4'(1 << w), NONE, NONE, 1'b0);
            add(1'b0, 4'b0000, NONE, g((w + 1) % 4), 1'b0);
        end

        scen_preempt(NONE, 1'b0);
`ifdef BUS_ARB_LOCK_EN
        scen_preempt(4'b1110, 1'b1);
`else
        scen_preempt(4'b1110, 1'b0);
`endif

        // Reset while M2 owns, then M0 gets the bus first.
        add(1'b1, 4'b0000, NONE, NONE, 1'b0);
        add(1'b0, 4'b1011, NONE, g(2), 1'b0);
        add(1'b0, 4'b1011, NONE, g(2), 1'b0);
        add(1'b1, 4'b0000, NONE, NONE, 1'b0);
        add(1'b0, 4'b0000, NONE, g(0), 1'b0);

        // Release coincides with the preempt condition: no pulse.
        add(1'b1, 4'b0000, NONE, NONE, 1'b0);
        for (int j = 0; j < 16; j++)
            add(1'b0, 4'b1100, NONE, g(0), 1'b0);
        add(1'b0, 4'b1101, NONE, NONE, 1'b0);
        add(1'b0, 4'b1101, NONE, g(1), 1'b0);

        // Tenure saturates alone, then a late requester preempts on the next edge.
        add(1'b1, 4'b0000, NONE, NONE, 1'b0);
        for (int j = 0; j < 20; j++)
            add(1'b0, 4'b1110, NONE, g(0), 1'b0);
        add(1'b0, 4'b1100, NONE, NONE, 1'b1);
        add(1'b0, 4'b1100, NONE, g(1), 1'b0);
        add(1'b0, 4'b1100, NONE, g(1), 1'b0);

        @(negedge bus_clk);
        for (int k = 0; k < vecs.size(); k++) begin
            vec_t e;
            vi             = k;
            bus_rst        = vecs[k].rst;
            bus_if.m_reqn  = vecs[k].reqn;
            bus_if.m_lockn = vecs[k].lockn;
            sb.push_back(vecs[k]);
            @(posedge bus_clk);
            #1;
            e = sb.pop_front();
            check("grntn", 32'(bus_if.m_grntn), 32'(e.grntn));
            check("vld", 32'(bus_if.bus_owner_vld), 32'(e.vld));
            check("pulse", 32'(bus_if.preempt_pulse), 32'(e.pulse));
            if (e.chk_owner)
                check("owner", 32'(bus_if.bus_owner), 32'(e.owner));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
